mem_master: RTL

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_master.sv
// ---------------------------------------------------------------------------
// mem_master
//
// Queues read/write commands in a small FIFO and replays them, strictly in
// order and one at a time, to a memory slave over a four-phase REQ/ACK
// handshake.
//
// Parameters
//   DEPTH    command FIFO entries (power of two, 2..16)
//   TIMEOUT  cycles to wait for ACK in ASSERT before abandoning a command
//            (only meaningful when MEM_MASTER_TIMEOUT_EN is defined)
//
// Optional feature
//   MEM_MASTER_TIMEOUT_EN  when defined, a stuck slave is abandoned after
//                          TIMEOUT cycles and err pulses for one cycle.
//                          When undefined, ASSERT waits forever and err = 0.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command offered
//   cmd_ready  FIFO not full (accept on cmd_valid && cmd_ready)
//   cmd_wr     1 = write, 0 = read
//   cmd_addr   byte address, forwarded unchanged to addr
//   cmd_wdata  write data
//   addr       address to slave (registered)
//   din        write data to slave (registered)
//   dout       read data from slave
//   req        handshake request (registered)
//   wen        write enable qualifying req (registered)
//   ack        slave acknowledge
//   rd_valid   one-cycle pulse, rd_data holds fresh read data
//   rd_data    last captured read data
//   busy       FIFO non-empty or FSM not idle
//   err        one-cycle timeout pulse
// ---------------------------------------------------------------------------
module mem_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic [15:0] addr,
  output logic [15:0] din,
  input  logic [15:0] dout,
  output logic        req,
  output logic        wen,
  input  logic        ack,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // FIFO entry layout: {wr, addr[15:0], wdata[15:0]}
  logic [32:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic [1:0]    state_reg;
  logic          req_reg;
  logic          wen_reg;
  logic [15:0]   addr_reg;
  logic [15:0]   din_reg;
  logic [15:0]   rd_data_reg;
  logic          rd_valid_reg;

  logic [32:0]   head;
  logic          push;
  logic          pop;
  logic          timeout_hit;

  assign cmd_ready = (count_reg != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  // A new command only leaves the FIFO once the slave has dropped ACK from
  // the previous handshake (or from whatever it was doing out of reset).
  assign pop       = (state_reg == ST_IDLE) && (count_reg != '0) && !ack;
  // The head is read combinationally so a command pushed into an empty FIFO
  // can be issued on the very next edge.
  assign head      = fifo_mem[rd_ptr_reg];
  assign busy      = (count_reg != '0) || (state_reg != ST_IDLE);

  assign req       = req_reg;
  assign wen       = wen_reg;
  assign addr      = addr_reg;
  assign din       = din_reg;
  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;

  // -------------------------------------------------------------------------
  // FIFO storage (contents need no reset; emptiness lives in count_reg)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_wr, cmd_addr, cmd_wdata};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Handshake FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      req_reg      <= 1'b0;
      wen_reg      <= 1'b0;
      addr_reg     <= '0;
      din_reg      <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            wen_reg   <= head[32];
            addr_reg  <= head[31:16];
            din_reg   <= head[15:0];
            req_reg   <= 1'b1;
            state_reg <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (ack) begin
            req_reg   <= 1'b0;
            state_reg <= ST_RELEASE;
            if (!wen_reg) begin
              rd_data_reg  <= dout;
              rd_valid_reg <= 1'b1;
            end
          end else if (timeout_hit) begin
            // Abandon the command: no read data is reported for it.
            req_reg   <= 1'b0;
            state_reg <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!ack) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Optional ACK timeout
  // -------------------------------------------------------------------------
`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_reg;
  logic          err_reg;

  // timer_reg counts completed ASSERT cycles; it is 0 on the first one, so
  // matching TIMEOUT-1 leaves REQ high for exactly TIMEOUT cycles.
  assign timeout_hit = (state_reg == ST_ASSERT) && !ack && (timer_reg == TIMEOUT_LAST);
  assign err         = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= timeout_hit;
      if (state_reg != ST_ASSERT) begin
        timer_reg <= '0;
      end else begin
        timer_reg <= timer_reg + TW'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule
